// File: rtl/bsg_dmc_trace_rd_checker.sv
// bsg_dmc_trace_rd_checker: drains trace read beats and checks them against a seeded incrementing pattern
module bsg_dmc_trace_rd_checker #(
  parameter int data_width_p  = 128,
  parameter int count_width_p = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [31:0]              seed_i,
  input  logic [count_width_p-1:0] expected_beats_i,
  input  logic [data_width_p-1:0]  data_i,
  input  logic                     v_i,
  output logic                     yumi_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [count_width_p-1:0] beat_count_o,
  output logic [count_width_p-1:0] err_count_o,
  output logic                     first_err_v_o,
  output logic [count_width_p-1:0] first_err_idx_o,
  output logic [31:0]              signature_o
);
  localparam int lanes_lp = data_width_p / 32;
  localparam logic [count_width_p-1:0] one_lp = 1;
  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_e;
  state_e state_r;
  logic [31:0] seed_r, base, lane_xor;
  logic [count_width_p-1:0] target_r;
  logic [data_width_p-1:0] exp_data;
  logic hs, mismatch, last;
  always_comb begin
    base = seed_r + 32'(beat_count_o) * 32'(lanes_lp);
    exp_data = '0;
    lane_xor = '0;
    for (int j = 0; j < lanes_lp; j++) begin
      exp_data[32*j+:32] = base + 32'(j);
      lane_xor = lane_xor ^ data_i[32*j+:32];
    end
  end
  assign busy_o   = state_r == CHECK;
  assign done_o   = state_r == DONE;
  assign pass_o   = done_o & (err_count_o == '0);
  assign yumi_o   = busy_o & v_i;
  assign hs       = yumi_o;
  assign mismatch = |(data_i ^ exp_data);
  assign last     = (beat_count_o + one_lp) == target_r;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r         <= IDLE;
      seed_r          <= '0;
      target_r        <= '0;
      beat_count_o    <= '0;
      err_count_o     <= '0;
      first_err_v_o   <= 1'b0;
      first_err_idx_o <= '0;
      signature_o     <= '0;
    end else if (start_i && state_r != CHECK) begin
      state_r         <= (expected_beats_i == '0) ? DONE : CHECK;
      seed_r          <= seed_i;
      target_r        <= expected_beats_i;
      beat_count_o    <= '0;
      err_count_o     <= '0;
      first_err_v_o   <= 1'b0;
      first_err_idx_o <= '0;
      signature_o     <= '0;
    end else if (hs) begin
      state_r      <= last ? DONE : CHECK;
      beat_count_o <= beat_count_o + one_lp;
      signature_o  <= {signature_o[30:0], signature_o[31]} ^ lane_xor;
      if (mismatch && err_count_o != '1)
        err_count_o <= err_count_o + one_lp;
      if (mismatch && !first_err_v_o) begin
        first_err_v_o   <= 1'b1;
        first_err_idx_o <= beat_count_o;
      end
    end
  end
endmodule

// File: tb/tb_bsg_dmc_trace_rd_checker.sv
// tb_bsg_dmc_trace_rd_checker: directed plus randomized runs checked against a transaction-level model
module tb_bsg_dmc_trace_rd_checker;
  logic clk = 0, reset_i = 1, start_i = 0, v_i = 0;
  logic [31:0] seed_i = '0, expected_beats_i = '0;
  logic [127:0] data_i = '0;
  logic yumi_o, busy_o, done_o, pass_o, first_err_v_o;
  logic [31:0] beat_count_o, err_count_o, first_err_idx_o, signature_o;
  logic yumi4, busy4, done4, pass4, fev4;
  logic [3:0] bc4, ec4, fei4;
  logic [31:0] sig4;
  int cmp = 0, fails = 0;
  int m_state;
  logic [31:0] m_seed, m_target, m_beats, m_err, m_fidx, m_sig;
  logic m_fv;

  always #5 clk = ~clk;

  bsg_dmc_trace_rd_checker dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .seed_i(seed_i),
    .expected_beats_i(expected_beats_i), .data_i(data_i), .v_i(v_i),
    .yumi_o(yumi_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .beat_count_o(beat_count_o), .err_count_o(err_count_o),
    .first_err_v_o(first_err_v_o), .first_err_idx_o(first_err_idx_o),
    .signature_o(signature_o));

  bsg_dmc_trace_rd_checker #(.data_width_p(128), .count_width_p(4)) dut4 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .seed_i(seed_i),
    .expected_beats_i(expected_beats_i[3:0]), .data_i(data_i), .v_i(v_i),
    .yumi_o(yumi4), .busy_o(busy4), .done_o(done4), .pass_o(pass4),
    .beat_count_o(bc4), .err_count_o(ec4),
    .first_err_v_o(fev4), .first_err_idx_o(fei4), .signature_o(sig4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_beat(input logic [31:0] s, input logic [31:0] k);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[32*j+:32] = s + k * 32'd4 + 32'(j);
    return r;
  endfunction

  task automatic check_all();
    chk("busy", 64'(busy_o), 64'(m_state == 1));
    chk("done", 64'(done_o), 64'(m_state == 2));
    chk("pass", 64'(pass_o), 64'(m_state == 2 && m_err == 0));
    chk("beat_count", 64'(beat_count_o), 64'(m_beats));
    chk("err_count", 64'(err_count_o), 64'(m_err));
    chk("first_err_v", 64'(first_err_v_o), 64'(m_fv));
    chk("first_err_idx", 64'(first_err_idx_o), 64'(m_fidx));
    chk("signature", 64'(signature_o), 64'(m_sig));
  endtask

  task automatic model_clear();
    m_beats = 0; m_err = 0; m_fv = 0; m_fidx = 0; m_sig = 0;
  endtask

  task automatic do_reset();
    reset_i = 1; v_i = 0; start_i = 0;
    @(posedge clk); @(negedge clk);
    reset_i = 0;
    m_state = 0; m_seed = 0; m_target = 0; model_clear();
    check_all();
  endtask

  task automatic start_run(input logic [31:0] s, input logic [31:0] n);
    start_i = 1; seed_i = s; expected_beats_i = n;
    if (m_state != 1) begin
      m_seed = s; m_target = n; model_clear();
      m_state = (n == 0) ? 2 : 1;
    end
    @(posedge clk); @(negedge clk);
    start_i = 0;
    check_all();
  endtask

  task automatic beat(input logic [127:0] d);
    logic [31:0] x;
    v_i = 1; data_i = d; #1;
    chk("yumi", 64'(yumi_o), 64'(m_state == 1));
    if (m_state == 1) begin
      if (d !== exp_beat(m_seed, m_beats)) begin
        if (m_err != 32'hffff_ffff) m_err++;
        if (!m_fv) begin m_fv = 1; m_fidx = m_beats; end
      end
      x = d[31:0] ^ d[63:32] ^ d[95:64] ^ d[127:96];
      m_sig = {m_sig[30:0], m_sig[31]} ^ x;
      m_beats++;
      if (m_beats == m_target) m_state = 2;
    end
    @(posedge clk); @(negedge clk);
    v_i = 0;
    check_all();
  endtask

  task automatic gap();
    v_i = 0; data_i = 128'($urandom); #1;
    chk("yumi_gap", 64'(yumi_o), 64'd0);
    @(posedge clk); @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [127:0] d;
    logic [31:0] s, n;
    @(negedge clk);
    do_reset();
    // idle gating
    beat(128'hdead_beef);
    chk("idle_yumi_sampled", 64'(beat_count_o), 64'd0);
    // single beat
    start_run(32'h1, 1);
    beat({32'd4, 32'd3, 32'd2, 32'd1});
    chk("single_sig", 64'(signature_o), 64'h4);
    chk("single_pass", 64'(pass_o), 64'd1);
    beat(128'h5);
    // corrupted beat 2
    start_run(32'h0, 4);
    for (int k = 0; k < 4; k++) begin
      d = exp_beat(0, 32'(k));
      if (k == 2) d[31:0] = 32'h9;
      beat(d);
    end
    chk("corrupt_err", 64'(err_count_o), 64'd1);
    chk("corrupt_idx", 64'(first_err_idx_o), 64'd2);
    chk("corrupt_pass", 64'(pass_o), 64'd0);
    // backpressure gaps
    start_run(32'h100, 3);
    for (int k = 0; k < 3; k++) begin
      beat(exp_beat(32'h100, 32'(k)));
      if (k < 2) begin gap(); gap(); end
    end
    chk("gap_done", 64'(done_o), 64'd1);
    // zero-length run
    start_run(32'h77, 0);
    chk("zero_pass", 64'(pass_o), 64'd1);
    // all 15 beats wrong, narrow counters
    start_run(32'h10, 15);
    for (int k = 0; k < 15; k++) beat(~exp_beat(32'h10, 32'(k)));
    chk("sat_err4", 64'(ec4), 64'd15);
    chk("sat_idx4", 64'(fei4), 64'd0);
    chk("sat_pass4", 64'(pass4), 64'd0);
    chk("sat_done4", 64'(done4), 64'd1);
    chk("sat_bc4", 64'(bc4), 64'd15);
    // reset mid-run then restart
    start_run(32'h55, 5);
    beat(exp_beat(32'h55, 0));
    beat(exp_beat(32'h55, 1));
    do_reset();
    beat(exp_beat(0, 0));
    start_run(32'h0, 2);
    beat(exp_beat(0, 0));
    beat(exp_beat(0, 1));
    chk("restart_pass", 64'(pass_o), 64'd1);
    // randomized runs with gaps, corruption and ignored starts
    for (int r = 0; r < 12; r++) begin
      s = $urandom; n = $urandom_range(1, 9);
      start_run(s, n);
      while (m_state == 1) begin
        d = exp_beat(s, m_beats);
        if ($urandom_range(0, 3) == 0) d[$urandom_range(0, 127)] ^= 1'b1;
        case ($urandom_range(0, 5))
          0: gap();
          1: start_run($urandom, $urandom_range(0, 4));
          default: beat(d);
        endcase
      end
      if ($urandom_range(0, 1) == 1) beat(128'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule

// File: doc/bsg_dmc_trace_rd_checker.md
Name: bsg_dmc_trace_rd_checker

Overview:
- Read-data consumer directly downstream of the DMC pearl's trace read-data port (data/v/yumi).
- In trace-replay test mode it drains replayed read beats and compares each against a deterministic expected pattern from a software-loaded seed.
- Accumulates beat count, error count, first-error index and a 32-bit signature.
- Reports pass/fail back to the test harness.

Parameters:
- data_width_p, 128: width of one read beat (equals pearl ui_data_width_p); must be a multiple of 32, lanes_lp = data_width_p/32.
- count_width_p, 32: width of the target, beat, error and index counters.

Ports:
- clk_i  in  1  ui clock domain clock.
- reset_i  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle pulse; arms a check run (accepted in IDLE or DONE only).
- seed_i  in  32  pattern base, sampled on accepted start_i.
- expected_beats_i  in  count_width_p  beats in the run, sampled on accepted start_i.
- data_i  in  data_width_p  read beat from pearl trace_data_o.
- v_i  in  1  beat valid (pearl trace_v_o).
- yumi_o  out  1  beat consumed (to pearl trace_yumi_i).
- busy_o  out  1  state == CHECK.
- done_o  out  1  state == DONE.
- pass_o  out  1  done_o & (err_count_o == 0).
- beat_count_o  out  count_width_p  beats consumed this run.
- err_count_o  out  count_width_p  mismatching beats; saturates at all-ones.
- first_err_v_o  out  1  at least one mismatch recorded this run.
- first_err_idx_o  out  count_width_p  beat index of the first mismatch.
- signature_o  out  32  running signature.

Behaviour:
- Reset: state=IDLE; yumi_o=0; every registered output=0; pass_o=0.
- Expected beat k, lane j (32-bit lane j occupies bits [32j+31:32j]): seed + k*lanes_lp + j, mod 2^32.
- Beat k is a mismatch if any bit differs from expected beat k.
- States:
  - IDLE: yumi_o=0 regardless of v_i; beats stay queued in the pearl.
  - IDLE/DONE + start_i:
    - latch seed and target; clear beat count, error count, first_err, signature.
    - go to CHECK; if expected_beats_i==0, go to DONE instead (pass_o=1 the next cycle).
  - CHECK:
    - yumi_o = v_i, combinational from the registered state only; no dependence on start_i.
    - start_i is ignored.
  - CHECK, on handshake (v_i & yumi_o), updates registered one cycle later:
    - beat_count += 1.
    - On mismatch: err_count += 1 unless already all-ones.
    - On the first mismatch: first_err_v=1 and first_err_idx = beat index before increment.
    - signature = rotl1(signature) ^ (XOR of all lanes of data_i).
  - CHECK -> DONE: on the handshake where beat_count+1 == target. done_o rises the next cycle, with all counters final in that same cycle.
  - DONE: yumi_o=0; outputs hold until start_i or reset_i.
- Beats with v_i=0 cycles (gaps) between them: no counter or signature change.
- reset_i asserted mid-CHECK: IDLE and all-zero state the next cycle. The partially consumed run is discarded; nothing is replayed.
- Counter wrap: beat_count never exceeds target, so no wrap.
- Only err_count saturates.
- Throughput: one beat per cycle sustained while v_i=1.
- Latency: data_i to counter and signature update is 1 cycle.

Test Plan:
- Single beat: data_width_p=128, seed=0x1, beats=1, data_i lanes {4,3,2,1} (lane0=1) -> yumi_o=1 that cycle; next cycle done_o=1, pass_o=1, beat_count_o=1, err_count_o=0, signature_o=0x00000004.
- Corrupted beat: seed=0, beats=4, beat 2 lane0 sent as 0x9 instead of 0x8 -> done_o=1, err_count_o=1, first_err_v_o=1, first_err_idx_o=2, pass_o=0.
- Backpressure gaps: seed=0x100, beats=3 with v_i idle 2 cycles between beats -> yumi_o only on valid cycles; beat_count_o=3, pass_o=1; done_o rises exactly one cycle after the 3rd handshake.
- Zero-length run and idle gating: v_i=1 while IDLE -> yumi_o=0. start_i with beats=0 -> done_o=1, pass_o=1, beat_count_o=0 next cycle.
- Saturation: count_width_p=4, beats=15, all beats wrong -> err_count_o=15, first_err_idx_o=0, pass_o=0.
- Reset/restart: reset_i after 2 of 5 beats -> all outputs 0 next cycle, yumi_o=0. Then start_i with seed=0, beats=2 and correct data -> pass_o=1, beat_count_o=2.
